// File: rtl/exe_mem_stage_if.sv
// ID/EXE -> EX/MEM stage bus: decoded instruction fields and WB bypass in,
// EX/MEM pipeline register contents out.
interface exe_mem_stage_if #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
);
    logic             WriteRegIn;
    logic             MemToRegIn;
    logic             writeMemIn;
    logic             BranchIn;
    logic             RegrtIn;
    logic [2:0]       ALUCIn;
    logic             ALUimmIn;
    logic [WIDTH-1:0] nextAddressIn;
    logic [WIDTH-1:0] R1OutputIn;
    logic [WIDTH-1:0] R2OutputIn;
    logic [WIDTH-1:0] signExtendIn;
    logic [REGW-1:0]  rsIn;
    logic [REGW-1:0]  rtIn;
    logic [REGW-1:0]  rdIn;
    logic             wbWriteEn;
    logic [REGW-1:0]  wbAddr;
    logic [WIDTH-1:0] wbData;
    logic             stall;
    logic             flush;
    logic             WriteRegOut;
    logic             MemToRegOut;
    logic             writeMemOut;
    logic [WIDTH-1:0] ALUResultOut;
    logic [WIDTH-1:0] storeDataOut;
    logic [REGW-1:0]  writeAddrOut;
    logic             branchTakenOut;
    logic [WIDTH-1:0] branchTargetOut;
    logic             validOut;

    modport master (
        output WriteRegIn, MemToRegIn, writeMemIn, BranchIn, RegrtIn, ALUCIn, ALUimmIn,
               nextAddressIn, R1OutputIn, R2OutputIn, signExtendIn, rsIn, rtIn, rdIn,
               wbWriteEn, wbAddr, wbData, stall, flush,
        input  WriteRegOut, MemToRegOut, writeMemOut, ALUResultOut, storeDataOut,
               writeAddrOut, branchTakenOut, branchTargetOut, validOut
    );

    modport slave (
        input  WriteRegIn, MemToRegIn, writeMemIn, BranchIn, RegrtIn, ALUCIn, ALUimmIn,
               nextAddressIn, R1OutputIn, R2OutputIn, signExtendIn, rsIn, rtIn, rdIn,
               wbWriteEn, wbAddr, wbData, stall, flush,
        output WriteRegOut, MemToRegOut, writeMemOut, ALUResultOut, storeDataOut,
               writeAddrOut, branchTakenOut, branchTargetOut, validOut
    );
endinterface

// File: rtl/exe_mem_stage.sv
// Execute stage of the 5-stage pipeline: operand forwarding, ALU, beq resolution,
// and the EX/MEM pipeline register with stall (hold) and flush (bubble).
module exe_mem_stage #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic           clk,
    input  logic           rst,
    exe_mem_stage_if.slave bus
);
    logic             exFwdOk_s;
    logic [WIDTH-1:0] opA_s;
    logic [WIDTH-1:0] rtFwd_s;
    logic [WIDTH-1:0] opB_s;
    logic [WIDTH-1:0] aluResult_s;
    logic [WIDTH-1:0] branchTarget_s;
    logic             branchTaken_s;
    logic [REGW-1:0]  writeAddr_s;

    // A load's EX/MEM value is an address, not the register data, so it is never bypassed
    always_comb begin
        exFwdOk_s = bus.validOut & bus.WriteRegOut & ~bus.MemToRegOut &
                    (bus.writeAddrOut != {REGW{1'b0}});
    end

    // rs operand: EX/MEM result is newer than WB, WB newer than the register file
    always_comb begin
        if (exFwdOk_s && (bus.writeAddrOut == bus.rsIn)) begin
            opA_s = bus.ALUResultOut;
        end else if (bus.wbWriteEn && (bus.wbAddr != {REGW{1'b0}}) && (bus.wbAddr == bus.rsIn)) begin
            opA_s = bus.wbData;
        end else begin
            opA_s = bus.R1OutputIn;
        end
    end

    // rt operand with the same priority; feeds store data, branch compare and ALU B
    always_comb begin
        if (exFwdOk_s && (bus.writeAddrOut == bus.rtIn)) begin
            rtFwd_s = bus.ALUResultOut;
        end else if (bus.wbWriteEn && (bus.wbAddr != {REGW{1'b0}}) && (bus.wbAddr == bus.rtIn)) begin
            rtFwd_s = bus.wbData;
        end else begin
            rtFwd_s = bus.R2OutputIn;
        end
    end

    // ALU; shifts use only the low five bits of B
    always_comb begin
        opB_s       = bus.ALUimmIn ? bus.signExtendIn : rtFwd_s;
        aluResult_s = {WIDTH{1'b0}};
        case (bus.ALUCIn)
            3'b000:  aluResult_s = opA_s + opB_s;
            3'b001:  aluResult_s = opA_s - opB_s;
            3'b010:  aluResult_s = opA_s & opB_s;
            3'b011:  aluResult_s = opA_s | opB_s;
            3'b100:  aluResult_s = opA_s ^ opB_s;
            3'b101:  aluResult_s = ($signed(opA_s) < $signed(opB_s)) ?
                                   {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
            3'b110:  aluResult_s = opA_s << opB_s[4:0];
            3'b111:  aluResult_s = ~(opA_s | opB_s);
            default: aluResult_s = {WIDTH{1'b0}};
        endcase
    end

    // beq decision always compares rs against the forwarded rt, never the immediate
    always_comb begin
        branchTaken_s  = bus.BranchIn & (opA_s == rtFwd_s);
        branchTarget_s = bus.nextAddressIn + {bus.signExtendIn[WIDTH-3:0], 2'b00};
        writeAddr_s    = bus.RegrtIn ? bus.rtIn : bus.rdIn;
    end

    // EX/MEM register: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            bus.WriteRegOut     <= 1'b0;
            bus.MemToRegOut     <= 1'b0;
            bus.writeMemOut     <= 1'b0;
            bus.ALUResultOut    <= {WIDTH{1'b0}};
            bus.storeDataOut    <= {WIDTH{1'b0}};
            bus.writeAddrOut    <= {REGW{1'b0}};
            bus.branchTakenOut  <= 1'b0;
            bus.branchTargetOut <= {WIDTH{1'b0}};
            bus.validOut        <= 1'b0;
        end else if (bus.stall) begin
            bus.WriteRegOut     <= bus.WriteRegOut;
            bus.MemToRegOut     <= bus.MemToRegOut;
            bus.writeMemOut     <= bus.writeMemOut;
            bus.ALUResultOut    <= bus.ALUResultOut;
            bus.storeDataOut    <= bus.storeDataOut;
            bus.writeAddrOut    <= bus.writeAddrOut;
            bus.branchTakenOut  <= bus.branchTakenOut;
            bus.branchTargetOut <= bus.branchTargetOut;
            bus.validOut        <= bus.validOut;
        end else begin
            bus.WriteRegOut     <= bus.WriteRegIn;
            bus.MemToRegOut     <= bus.MemToRegIn;
            bus.writeMemOut     <= bus.writeMemIn;
            bus.ALUResultOut    <= aluResult_s;
            bus.storeDataOut    <= rtFwd_s;
            bus.writeAddrOut    <= writeAddr_s;
            bus.branchTakenOut  <= branchTaken_s;
            bus.branchTargetOut <= branchTarget_s;
            bus.validOut        <= 1'b1;
        end
    end
endmodule

// File: tb/tb_exe_mem_stage.sv
// Table-driven bench for exe_mem_stage with an expected-result queue and a
// hand-written dependent-add chain through the EX/MEM bypass.
module tb_exe_mem_stage;
    logic clk;
    logic rst;
    int   nAssert = 0;
    int   nFail   = 0;

    exe_mem_stage_if #(.WIDTH(32), .REGW(5)) bus ();
    exe_mem_stage #(.WIDTH(32), .REGW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, wr, m2r, wm, br, regrt;
        logic [2:0]  aluc;
        logic        imm;
        logic [31:0] nxt, r1, r2, se;
        logic [4:0]  rs, rt, rd;
        logic        wbEn;
        logic [4:0]  wbAddr;
        logic [31:0] wbData;
        logic        stall, flush;
    } stim_t;

    typedef struct packed {
        logic        wr, m2r, wm, bt, valid;
        logic [31:0] res, store, btgt;
        logic [4:0]  waddr;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic drive(input stim_t s);
        rst               = s.rst;
        bus.WriteRegIn    = s.wr;
        bus.MemToRegIn    = s.m2r;
        bus.writeMemIn    = s.wm;
        bus.BranchIn      = s.br;
        bus.RegrtIn       = s.regrt;
        bus.ALUCIn        = s.aluc;
        bus.ALUimmIn      = s.imm;
        bus.nextAddressIn = s.nxt;
        bus.R1OutputIn    = s.r1;
        bus.R2OutputIn    = s.r2;
        bus.signExtendIn  = s.se;
        bus.rsIn          = s.rs;
        bus.rtIn          = s.rt;
        bus.rdIn          = s.rd;
        bus.wbWriteEn     = s.wbEn;
        bus.wbAddr        = s.wbAddr;
        bus.wbData        = s.wbData;
        bus.stall         = s.stall;
        bus.flush         = s.flush;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", nm, idx, act, exp);
        end
    endtask

    task automatic compare(input int idx);
        exp_t e;
        nAssert++;
        if (sb.size() == 0) begin
            nFail++;
            $display("FAIL scoreboard step %0d: got empty queue expected an entry", idx);
        end else begin
            e = sb.pop_front();
            chk("WriteRegOut",     idx, {31'd0, bus.WriteRegOut},    {31'd0, e.wr});
            chk("MemToRegOut",     idx, {31'd0, bus.MemToRegOut},    {31'd0, e.m2r});
            chk("writeMemOut",     idx, {31'd0, bus.writeMemOut},    {31'd0, e.wm});
            chk("ALUResultOut",    idx, bus.ALUResultOut,            e.res);
            chk("storeDataOut",    idx, bus.storeDataOut,            e.store);
            chk("writeAddrOut",    idx, {27'd0, bus.writeAddrOut},   {27'd0, e.waddr});
            chk("branchTakenOut",  idx, {31'd0, bus.branchTakenOut}, {31'd0, e.bt});
            chk("branchTargetOut", idx, bus.branchTargetOut,         e.btgt);
            chk("validOut",        idx, {31'd0, bus.validOut},       {31'd0, e.valid});
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        drive(v.s);
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        compare(idx);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        vec_t held;
        // 0: reset with every input nonzero, stall and flush also up
        v = '0; v.s.rst = 1'b1; v.s.wr = 1'b1; v.s.m2r = 1'b1; v.s.wm = 1'b1; v.s.br = 1'b1; v.s.regrt = 1'b1;
        v.s.aluc = 3'd3; v.s.imm = 1'b1; v.s.nxt = 32'd4; v.s.r1 = 32'd5; v.s.r2 = 32'd5; v.s.se = 32'd1;
        v.s.rs = 5'd1; v.s.rt = 5'd2; v.s.rd = 5'd3; v.s.wbEn = 1'b1; v.s.wbAddr = 5'd1; v.s.wbData = 32'd7;
        v.s.stall = 1'b1; v.s.flush = 1'b1; vecs.push_back(v);
        // 1: immediate add 9+11 into rt=13
        v = '0; v.s.wr = 1'b1; v.s.regrt = 1'b1; v.s.imm = 1'b1; v.s.r1 = 32'd9; v.s.se = 32'd11; v.s.rs = 5'd1; v.s.rt = 5'd13;
        v.e.wr = 1'b1; v.e.res = 32'd20; v.e.waddr = 5'd13; v.e.btgt = 32'd44; v.e.valid = 1'b1; vecs.push_back(v);
        // 2: r5 = 0x10
        v = '0; v.s.wr = 1'b1; v.s.imm = 1'b1; v.s.r1 = 32'h10; v.s.rt = 5'd6; v.s.r2 = 32'd3; v.s.rd = 5'd5;
        v.e.wr = 1'b1; v.e.res = 32'h10; v.e.store = 32'd3; v.e.waddr = 5'd5; v.e.valid = 1'b1; vecs.push_back(v);
        // 3: rs=5 from EX/MEM beats WB r5=0x99
        v = '0; v.s.wr = 1'b1; v.s.imm = 1'b1; v.s.rs = 5'd5; v.s.se = 32'd1; v.s.rt = 5'd8; v.s.r2 = 32'h22; v.s.rd = 5'd7;
        v.s.wbEn = 1'b1; v.s.wbAddr = 5'd5; v.s.wbData = 32'h99;
        v.e.wr = 1'b1; v.e.res = 32'h11; v.e.store = 32'h22; v.e.waddr = 5'd7; v.e.btgt = 32'd4; v.e.valid = 1'b1; vecs.push_back(v);
        // 4: rs=5 only from WB; rt=7 from EX/MEM into store data
        v = '0; v.s.wr = 1'b1; v.s.imm = 1'b1; v.s.rs = 5'd5; v.s.se = 32'd1; v.s.rt = 5'd7; v.s.rd = 5'd9;
        v.s.wbEn = 1'b1; v.s.wbAddr = 5'd5; v.s.wbData = 32'h99;
        v.e.wr = 1'b1; v.e.res = 32'h9A; v.e.store = 32'h11; v.e.waddr = 5'd9; v.e.btgt = 32'd4; v.e.valid = 1'b1; vecs.push_back(v);
        // 5: rs=rt=0 with WB writing r0: no forwarding; destination r0
        v = '0; v.s.wr = 1'b1; v.s.imm = 1'b1; v.s.r1 = 32'h40; v.s.se = 32'd2; v.s.r2 = 32'd5;
        v.s.wbEn = 1'b1; v.s.wbData = 32'h99;
        v.e.wr = 1'b1; v.e.res = 32'h42; v.e.store = 32'd5; v.e.btgt = 32'd8; v.e.valid = 1'b1; vecs.push_back(v);
        // 6: EX/MEM holds a write to r0: still no forwarding (or 3|0x30)
        v = '0; v.s.regrt = 1'b1; v.s.aluc = 3'd3; v.s.r1 = 32'd3; v.s.r2 = 32'h30; v.s.wbEn = 1'b1; v.s.wbData = 32'h99;
        v.e.res = 32'h33; v.e.store = 32'h30; v.e.valid = 1'b1; vecs.push_back(v);
        // 7: beq taken, immediate selected for ALU B but not for the compare
        v = '0; v.s.br = 1'b1; v.s.imm = 1'b1; v.s.r1 = 32'd10; v.s.r2 = 32'd10; v.s.nxt = 32'd8; v.s.se = 32'd3;
        v.s.rs = 5'd2; v.s.rt = 5'd3; v.s.rd = 5'd4;
        v.e.res = 32'd13; v.e.store = 32'd10; v.e.waddr = 5'd4; v.e.bt = 1'b1; v.e.btgt = 32'd20; v.e.valid = 1'b1; vecs.push_back(v);
        // 8: beq not taken
        v.s.r2 = 32'd11; v.e.store = 32'd11; v.e.bt = 1'b0; vecs.push_back(v);
        // 9-15: ALU corners and logic ops
        v = '0; v.s.rs = 5'd1; v.s.rt = 5'd2; v.s.rd = 5'd3; v.e.waddr = 5'd3; v.e.valid = 1'b1;
        v.s.aluc = 3'd1; v.s.r1 = 32'd0; v.s.r2 = 32'd1; v.e.res = 32'hFFFF_FFFF; v.e.store = 32'd1; vecs.push_back(v);
        v.s.aluc = 3'd5; v.s.r1 = 32'hFFFF_FFFF; v.s.r2 = 32'd1; v.e.res = 32'd1; v.e.store = 32'd1; vecs.push_back(v);
        v.s.aluc = 3'd6; v.s.r1 = 32'd1; v.s.r2 = 32'd33; v.e.res = 32'd2; v.e.store = 32'd33; vecs.push_back(v);
        v.s.aluc = 3'd7; v.s.r1 = 32'd0; v.s.r2 = 32'd0; v.e.res = 32'hFFFF_FFFF; v.e.store = 32'd0; vecs.push_back(v);
        v.s.aluc = 3'd0; v.s.r1 = 32'hFFFF_FFFF; v.s.r2 = 32'd1; v.e.res = 32'd0; v.e.store = 32'd1; vecs.push_back(v);
        v.s.aluc = 3'd2; v.s.r1 = 32'hF0F0; v.s.r2 = 32'hFF00; v.e.res = 32'hF000; v.e.store = 32'hFF00; vecs.push_back(v);
        v.s.aluc = 3'd4; v.e.res = 32'h0FF0; vecs.push_back(v);
        // 16: load-type instruction writing r10
        v = '0; v.s.wr = 1'b1; v.s.m2r = 1'b1; v.s.wm = 1'b1; v.s.regrt = 1'b1; v.s.imm = 1'b1; v.s.r1 = 32'h100; v.s.se = 32'd4;
        v.s.rs = 5'd1; v.s.rt = 5'd10; v.s.r2 = 32'h55;
        v.e.wr = 1'b1; v.e.m2r = 1'b1; v.e.wm = 1'b1; v.e.res = 32'h104; v.e.store = 32'h55; v.e.waddr = 5'd10;
        v.e.btgt = 32'd16; v.e.valid = 1'b1; vecs.push_back(v);
        // 17: rs=10 must not take the load's EX/MEM value
        v = '0; v.s.imm = 1'b1; v.s.rs = 5'd10; v.s.r1 = 32'd7; v.s.rd = 5'd3;
        v.e.res = 32'd7; v.e.waddr = 5'd3; v.e.valid = 1'b1; vecs.push_back(v);
        // 18: instruction that will be held by stall
        v = '0; v.s.wr = 1'b1; v.s.wm = 1'b1; v.s.br = 1'b1; v.s.aluc = 3'd3; v.s.r1 = 32'h0A; v.s.r2 = 32'h50;
        v.s.rs = 5'd1; v.s.rt = 5'd2; v.s.rd = 5'd6; v.s.nxt = 32'h100; v.s.se = 32'd1;
        v.e.wr = 1'b1; v.e.wm = 1'b1; v.e.res = 32'h5A; v.e.store = 32'h50; v.e.waddr = 5'd6; v.e.btgt = 32'h104;
        v.e.valid = 1'b1; vecs.push_back(v); held = v;
        // 19-20: stall with changing inputs holds everything
        v = held; v.s = '0; v.s.stall = 1'b1; v.s.br = 1'b1; v.s.r1 = 32'd1; v.s.r2 = 32'd1; v.s.rs = 5'd6; v.s.rt = 5'd6; v.s.rd = 5'd1;
        vecs.push_back(v);
        v.s.m2r = 1'b1; v.s.aluc = 3'd7; v.s.r1 = 32'h77; v.s.rs = 5'd2; v.s.rd = 5'd9; vecs.push_back(v);
        // 21: held EX/MEM result is forwarded once stall drops
        v = '0; v.s.wr = 1'b1; v.s.imm = 1'b1; v.s.rs = 5'd6; v.s.rt = 5'd2; v.s.r2 = 32'd3; v.s.rd = 5'd8;
        v.e.wr = 1'b1; v.e.res = 32'h5A; v.e.store = 32'd3; v.e.waddr = 5'd8; v.e.valid = 1'b1; vecs.push_back(v);
        // 22: flush together with stall gives a bubble
        v = '0; v.s.stall = 1'b1; v.s.flush = 1'b1; v.s.wr = 1'b1; v.s.wm = 1'b1; v.s.br = 1'b1; v.s.r1 = 32'd1; v.s.r2 = 32'd1;
        v.s.rs = 5'd1; v.s.rt = 5'd1; v.s.rd = 5'd1; v.s.imm = 1'b1; v.s.se = 32'd5; v.s.nxt = 32'd4; vecs.push_back(v);
        // 23-24: load, then reset during stall
        v = '0; v.s.wr = 1'b1; v.s.imm = 1'b1; v.s.r1 = 32'd1; v.s.se = 32'd1; v.s.rs = 5'd1; v.s.rt = 5'd2; v.s.rd = 5'd3;
        v.e.wr = 1'b1; v.e.res = 32'd2; v.e.waddr = 5'd3; v.e.btgt = 32'd4; v.e.valid = 1'b1; vecs.push_back(v);
        v = '0; v.s.rst = 1'b1; v.s.stall = 1'b1; v.s.wr = 1'b1; v.s.r1 = 32'd9; v.s.rs = 5'd1; vecs.push_back(v);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // Dependent add chain r4 = r4 + 1 at full rate through the EX/MEM bypass
        for (int i = 0; i < 4; i++) begin
            v = '0; v.s.wr = 1'b1; v.s.imm = 1'b1; v.s.se = 32'd1; v.s.rd = 5'd4;
            v.s.rs = (i == 0) ? 5'd0 : 5'd4;
            v.e.wr = 1'b1; v.e.res = 32'(i + 1); v.e.waddr = 5'd4; v.e.btgt = 32'd4; v.e.valid = 1'b1;
            step(v, 100 + i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule

// File: doc/exe_mem_stage.md
Name: exe_mem_stage

Overview:
- Consumer end of the ID/EXE pipeline register; feeds the MEM stage.
- Takes the registered ID/EXE control and data fields, resolves operand forwarding, computes the ALU result and the branch decision.
- Latches the results into the EX/MEM pipeline register, with stall (hold) and flush (bubble) control.
- Sits between the ID_EXE register and the data-memory stage of the 5-stage MIPS-style pipeline.

Parameters:
- WIDTH, 32, datapath width.
- REGW, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- WriteRegIn  in  1  register-write enable from ID/EXE.
- MemToRegIn  in  1  load select from ID/EXE.
- writeMemIn  in  1  store enable from ID/EXE.
- BranchIn  in  1  beq instruction flag.
- RegrtIn  in  1  1 selects rt as destination; 0 selects rd.
- ALUCIn  in  3  ALU operation code.
- ALUimmIn  in  1  1 selects signExtendIn as operand B.
- nextAddressIn  in  WIDTH  PC+4 of the instruction.
- R1OutputIn  in  WIDTH  rs read data.
- R2OutputIn  in  WIDTH  rt read data.
- signExtendIn  in  WIDTH  sign-extended immediate.
- rsIn, rtIn, rdIn  in  REGW each  register addresses.
- wbWriteEn  in  1  WB-stage register-write enable.
- wbAddr  in  REGW  WB destination address.
- wbData  in  WIDTH  WB write data.
- stall  in  1  hold the EX/MEM register.
- flush  in  1  load a bubble into the EX/MEM register.
- WriteRegOut, MemToRegOut, writeMemOut  out  1 each  registered controls.
- ALUResultOut  out  WIDTH  registered ALU result.
- storeDataOut  out  WIDTH  registered forwarded rt value.
- writeAddrOut  out  REGW  registered destination address.
- branchTakenOut  out  1  registered branch-taken flag.
- branchTargetOut  out  WIDTH  registered branch target.
- validOut  out  1  registered slot-holds-instruction flag.

Behaviour:
Reset:
- rst=1 at an edge clears every output to 0.
- Reset has priority over flush and stall.
- Reset mid-stall or mid-flush still clears everything.

Forwarding, combinational, evaluated per operand (A uses rsIn/R1OutputIn, B-raw uses rtIn/R2OutputIn):
- Priority 1, EX/MEM: validOut & WriteRegOut & !MemToRegOut & writeAddrOut!=0 & writeAddrOut==addr gives ALUResultOut.
- Priority 2, WB: wbWriteEn & wbAddr!=0 & wbAddr==addr gives wbData.
- Otherwise the register-file value is used.
- Address 0 is never forwarded.

ALU:
- A = forwarded rs value.
- B = ALUimmIn ? signExtendIn : forwarded rt value.
- ALUC codes:
  - 000 add, wrap mod 2^WIDTH, no overflow trap.
  - 001 sub.
  - 010 and.
  - 011 or.
  - 100 xor.
  - 101 signed slt, result 1 or 0.
  - 110 sll A by B[4:0].
  - 111 nor.

Branch:
- taken = BranchIn & (forwarded rs == forwarded rt); this compare ignores ALUimmIn.
- target = nextAddressIn + (signExtendIn << 2), wrapping.

Destination:
- writeAddr = RegrtIn ? rtIn : rdIn.

EX/MEM register update at each rising edge, in priority order:
- rst: all outputs 0.
- flush: WriteRegOut, MemToRegOut, writeMemOut, branchTakenOut, validOut are 0; data fields are don't-care and are driven to 0.
- stall: all outputs hold.
- Otherwise: load the computed values; validOut=1.
- flush and stall together: flush wins.

Stall behaviour:
- While stall=1, EX/MEM forwarding still uses the held outputs.
- Latency is 1 cycle from input to output; throughput is 1 per cycle when not stalled.

Test Plan:
- Reset: assert rst 1 cycle with all inputs nonzero -> every output 0, validOut=0.
- Immediate add: R1OutputIn=9, signExtendIn=11, ALUimmIn=1, ALUCIn=000, RegrtIn=1, rtIn=13, WriteRegIn=1 -> next edge ALUResultOut=20, writeAddrOut=13, WriteRegOut=1, validOut=1.
- Back-to-back forwarding: cycle 1 writes r5=0x10 (add); cycle 2 has rsIn=5, R1OutputIn=0, signExtendIn=1 with wbWriteEn=1, wbAddr=5, wbData=0x99 -> ALUResultOut=0x11 (EX/MEM beats WB). Repeat with rsIn=0 -> no forwarding.
- Branch: BranchIn=1, R1=R2=10, nextAddressIn=8, signExtendIn=3 -> branchTakenOut=1, branchTargetOut=20. With R2=11 -> branchTakenOut=0.
- Stall/flush: load an instruction, hold stall=1 for 2 cycles with new inputs -> outputs unchanged. Then flush=1 together with stall=1 -> validOut, WriteRegOut, writeMemOut all 0.
- ALU corners:
  - sub 0-1 gives 0xFFFFFFFF.
  - slt 0xFFFFFFFF vs 1 gives 1.
  - sll 1 by 33 gives 2.
  - nor 0,0 gives 0xFFFFFFFF.
  - add 0xFFFFFFFF+1 gives 0.
